sc_dmem_responder: RTL and testbench

Data-side memory responder for the single-cycle MIPS CPU: it answers the CPU's data-port accesses (address, store data, write enable) with read data in the same cycle. It contains a word-addressed data RAM and a small memory-mapped I/O page. The I/O page holds a byte transmit FIFO drained over a valid/ready handshake, plus a free-running cycle counter. It sits between the CPU datapath's ALU-result/store-data outputs and its memory-read input.

---
 rtl/sc_dmem_responder_if.sv | 21 ++
 rtl/sc_dmem_responder.sv | 109 ++++++++++
 tb/tb_sc_dmem_responder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_dmem_responder_if.sv
// Data-port bus between the single-cycle CPU and sc_dmem_responder:
// CPU load/store signals plus the TX byte stream handshake.
interface sc_dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output addr, wdata, we, out_ready,
    input  rdata, out_data, out_valid
  );

  modport slave (
    input  addr, wdata, we, out_ready,
    output rdata, out_data, out_valid
  );
endinterface

// File: rtl/sc_dmem_responder.sv
// Data-side memory responder for the single-cycle MIPS CPU.
// Word-addressed RAM with combinational read, plus an I/O page at 0xFF00:
//   FF00 TXDATA (push byte), FF04 STATUS, FF08 CYCLE.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN enables the free-running
// cycle counter; without it CYCLE reads 0 and ignores writes.
module sc_dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  sc_dmem_responder_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [31:0]           mem_q  [2**ADDR_WIDTH];
  logic [7:0]            fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  in_page, ram_sel, tx_sel, status_sel, cycle_sel;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  empty, full, push, pop, push_ok;
  logic [31:0]           cycle_rd;
  logic [31:0]           rdata_c;
  logic                  unused_addr_lo;

  assign unused_addr_lo = ^bus.addr[1:0];

  // Address decode; bits [1:0] are don't-care, upper RAM index bits alias
  assign in_page    = (bus.addr[31:16] == 16'h0000);
  assign ram_sel    = in_page && (bus.addr[15:8] != 8'hFF);
  assign tx_sel     = in_page && (bus.addr[15:2] == 14'h3FC0);
  assign status_sel = in_page && (bus.addr[15:2] == 14'h3FC1);
  assign cycle_sel  = in_page && (bus.addr[15:2] == 14'h3FC2);
  assign word_idx   = bus.addr[ADDR_WIDTH+1:2];

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = !empty && bus.out_ready;
  assign push    = bus.we && tx_sel;
  // A pop on the same edge frees the slot, so a full FIFO still accepts
  assign push_ok = push && (!full || pop);

  // FIFO pointer/count/overflow next state; overflow set beats clear
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop);
    ovf_d   = ovf_q;
    if (bus.we && status_sel && bus.wdata[2]) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  // FIFO control state with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage arrays: not reset, RAM survives reset, FIFO slots gated by count
  always_ff @(posedge clock) begin
    if (bus.we && ram_sel) mem_q[word_idx] <= bus.wdata;
    if (push_ok) fifo_q[tail_q] <= bus.wdata[7:0];
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;

  // Counter loads on a CYCLE write, otherwise increments and wraps
  always_comb begin
    cycle_d = cycle_q + 32'd1;
    if (bus.we && cycle_sel) cycle_d = bus.wdata;
  end

  // Cycle counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  assign cycle_rd = cycle_q;
`else
  assign cycle_rd = '0;
`endif

  // Load data mux: combinational from address and pre-edge state
  always_comb begin
    rdata_c = '0;
    if (ram_sel)         rdata_c = mem_q[word_idx];
    else if (status_sel) rdata_c = {16'h0000, 8'(count_q), 5'b00000, ovf_q, full, empty};
    else if (cycle_sel)  rdata_c = cycle_rd;
  end

  assign bus.rdata     = rdata_c;
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : fifo_q[head_q];
endmodule

// File: tb/tb_sc_dmem_responder.sv
module tb_sc_dmem_responder;
  localparam int DEPTH = 4;
`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  sc_dmem_responder_if bus();

  sc_dmem_responder #(.ADDR_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [31:0] ram_m [256];
  logic [7:0]  q_m [$];
  logic        ovf_m;
  logic [31:0] cyc_m;

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a[31:16] != 16'h0) return 32'h0;
    if (a[15:8] != 8'hFF) return ram_m[a[9:2]];
    if (a[15:2] == 14'h3FC1)
      return {16'h0, 8'(q_m.size()), 5'b0, ovf_m, q_m.size() == DEPTH, q_m.size() == 0};
    if (a[15:2] == 14'h3FC2) return CYC_EN ? cyc_m : 32'h0;
    return 32'h0;
  endfunction

  task automatic model_reset();
    q_m.delete();
    ovf_m = 1'b0;
    cyc_m = 32'h0;
  endtask

  task automatic model_edge(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bit pg, pop;
    pg  = (a[31:16] == 16'h0);
    pop = (q_m.size() != 0) && r;
    if (w && pg && a[15:8] != 8'hFF) ram_m[a[9:2]] = d;
    if (pop) void'(q_m.pop_front());
    if (w && pg && a[15:2] == 14'h3FC1 && d[2]) ovf_m = 1'b0;
    if (w && pg && a[15:2] == 14'h3FC0) begin
      if (q_m.size() < DEPTH) q_m.push_back(d[7:0]);
      else ovf_m = 1'b1;
    end
    if (CYC_EN && w && pg && a[15:2] == 14'h3FC2) cyc_m = d;
    else cyc_m = cyc_m + 32'd1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    bus.addr = a; bus.wdata = d; bus.we = w; bus.out_ready = r;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge(bus.addr, bus.wdata, bus.we, bus.out_ready);
    #1;
  endtask

  task automatic test_reset();
    drive(32'hFF04, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    n_tests++;
    if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
    n_tests++;
    if (bus.rdata !== 32'h1) begin n_fail++; $display("FAIL reset_status got=%h exp=00000001", bus.rdata); end
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_ram();
    logic [31:0] old;
    for (int i = 0; i < 256; i++) begin
      drive(32'(i * 4), $urandom, 1'b1, 1'b0);
      step();
    end
    old = ram_m[4];
    drive(32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (bus.rdata !== old) begin n_fail++; $display("FAIL ram_same_cycle got=%h exp=%h", bus.rdata, old); end
    step();
    drive(32'h10, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ram_load got=%h exp=deadbeef", bus.rdata); end
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 4) == 0) a = {16'($urandom_range(1, 65535)), 16'($urandom)};
      else a = {16'h0, 16'($urandom_range(0, 16'hFEFF))};
      drive(a, $urandom, 1'($urandom), 1'b0);
      #1;
      n_tests++;
      if (bus.rdata !== exp_rdata(a)) begin n_fail++; $display("FAIL ram_rand a=%h got=%h exp=%h", a, bus.rdata, exp_rdata(a)); end
      step();
    end
  endtask

  task automatic test_fifo_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(32'hFF00, 32'h41 + 32'(i), 1'b1, 1'b0);
      step();
    end
    drive(32'hFF04, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (bus.rdata !== 32'h0402) begin n_fail++; $display("FAIL fifo_full_status got=%h exp=00000402", bus.rdata); end
    drive(32'hFF00, 32'h45, 1'b1, 1'b0);
    step();
    drive(32'hFF04, 32'h0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (bus.rdata !== 32'h0406) begin n_fail++; $display("FAIL fifo_ovf_status got=%h exp=00000406", bus.rdata); end
    n_tests++;
    if (bus.out_data !== 8'h41) begin n_fail++; $display("FAIL fifo_ovf_head got=%h exp=41", bus.out_data); end
  endtask

  task automatic test_drain();
    drive(32'hFF04, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(8'h41 + i)) begin
        n_fail++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out_data, 8'(8'h41 + i));
      end
      step();
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid); end
    n_tests++;
    if (bus.rdata !== 32'h5) begin n_fail++; $display("FAIL drain_status got=%h exp=00000005", bus.rdata); end
    drive(32'hFF04, 32'h4, 1'b1, 1'b1);
    step();
    drive(32'hFF04, 32'h0, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (bus.rdata !== 32'h1) begin n_fail++; $display("FAIL ovf_clear got=%h exp=00000001", bus.rdata); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [$];
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp.push_back(b);
      drive(32'hFF00, {24'h0, b}, 1'b1, 1'b0);
      step();
    end
    exp.push_back(8'h55);
    drive(32'hFF00, 32'h55, 1'b1, 1'b1);
    step();
    drive(32'hFF04, 32'h0, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (bus.rdata !== 32'h0402) begin n_fail++; $display("FAIL pushpop_status got=%h exp=00000402", bus.rdata); end
    void'(exp.pop_front());
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bus.out_data !== exp[i]) begin n_fail++; $display("FAIL pushpop_order_%0d got=%h exp=%h", i, bus.out_data, exp[i]); end
      step();
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_cycle();
    logic [31:0] e [3];
    if (CYC_EN) begin e[0] = 32'hFFFFFFFE; e[1] = 32'hFFFFFFFF; e[2] = 32'h0; end
    else begin e[0] = 32'h0; e[1] = 32'h0; e[2] = 32'h0; end
    drive(32'hFF08, 32'hFFFFFFFE, 1'b1, 1'b0);
    step();
    drive(32'hFF08, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (bus.rdata !== e[i]) begin n_fail++; $display("FAIL cycle_%0d got=%h exp=%h", i, bus.rdata, e[i]); end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int idx [3];
    for (int i = 0; i < 3; i++) begin
      drive(32'hFF00, 32'h60 + 32'(i), 1'b1, 1'b0);
      step();
    end
    drive(32'hFF04, 32'h0, 1'b0, 1'b1);
    step();
    #3;
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", bus.out_valid); end
    n_tests++;
    if (bus.rdata !== 32'h1) begin n_fail++; $display("FAIL rstmid_status got=%h exp=00000001", bus.rdata); end
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    idx[0] = 4; idx[1] = 0; idx[2] = int'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) begin
      drive(32'(idx[i] * 4), 32'h0, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (bus.rdata !== ram_m[idx[i]]) begin n_fail++; $display("FAIL rstmid_ram_%0d got=%h exp=%h", idx[i], bus.rdata, ram_m[idx[i]]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      logic w;
      int k;
      k = int'($urandom_range(0, 9));
      d = $urandom;
      w = 1'($urandom);
      case (k)
        0, 1, 2: begin a = 32'hFF00 | 32'($urandom_range(0, 3)); w = ($urandom_range(0, 3) != 0); end
        3:       a = 32'hFF04;
        4:       a = 32'hFF08;
        5:       a = 32'hFF00 + 32'(4 * $urandom_range(3, 63));
        6:       a = {16'($urandom_range(1, 65535)), 16'hFF00};
        default: a = {16'h0, 16'($urandom_range(0, 16'hFEFF))};
      endcase
      drive(a, d, w, 1'($urandom_range(0, 2) == 0));
      #1;
      n_tests++;
      if (bus.rdata !== exp_rdata(a)) begin n_fail++; $display("FAIL rand_rdata a=%h got=%h exp=%h", a, bus.rdata, exp_rdata(a)); end
      n_tests++;
      if (bus.out_valid !== (q_m.size() != 0) || bus.out_data !== (q_m.size() != 0 ? q_m[0] : 8'h00)) begin
        n_fail++; $display("FAIL rand_out got=%b/%h exp=%b/%h", bus.out_valid, bus.out_data, q_m.size() != 0, q_m.size() != 0 ? q_m[0] : 8'h00);
      end
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_ram();
    test_fifo_overflow();
    test_drain();
    test_full_push_pop();
    test_cycle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
